// File: rtl/divseq_pkg.sv
// divseq_pkg: state encoding and sizing helpers shared by the divseq unit.
package divseq_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int calc_n(input int xlen, input int radix_bits);
        return xlen / radix_bits;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divseq_step.sv
// divseq_step: one combinational restoring-division step.
module divseq_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;

    // A set top bit means the true shifted value exceeds any divisor.
    always_comb begin
        shifted = {rem_i[XLEN-1:0], bit_i};
        q_o     = rem_i[XLEN] | (shifted >= {1'b0, dvs_i});
        rem_o   = q_o ? shifted - {1'b0, dvs_i} : shifted;
    end

endmodule

// File: rtl/divseq.sv
// divseq: iterative signed/unsigned divider, RADIX_BITS quotient bits per cycle,
// with single-cycle divide-by-zero and signed-overflow results.
module divseq
    import divseq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld,
    output logic            rdy,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sgn,
    output logic            ack,
    input  logic            ack_rdy,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            dz,
    output logic            ovf
);

    localparam int N  = calc_n(XLEN, RADIX_BITS);
    localparam int CW = cnt_w(N);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [XLEN:0]   rp_q, rp_d;
    logic            negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, ovf_q, ovf_d;

    logic [XLEN:0]       r_chain [RADIX_BITS+1];
    logic                q_chain [RADIX_BITS];
    logic [XLEN-1:0]     qbits, dvd_next, rem_next;

    assign r_chain[0] = rp_q;

    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        divseq_step #(.XLEN(XLEN)) u_step (
            .rem_i (r_chain[g]),
            .bit_i (dvd_q[XLEN-1-g]),
            .dvs_i (dvs_q),
            .rem_o (r_chain[g+1]),
            .q_o   (q_chain[g])
        );
    end

    // Quotient bits shift into the dividend register as its bits are consumed.
    always_comb begin
        qbits = '0;
        for (int i = 0; i < RADIX_BITS; i++) qbits[RADIX_BITS-1-i] = q_chain[i];
        dvd_next = (dvd_q << RADIX_BITS) | qbits;
        rem_next = r_chain[RADIX_BITS][XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rp_d    = rp_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (vld) begin
                if (b == '0) begin
                    quo_d   = '1;
                    rem_d   = a;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else if (sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
                    quo_d   = a;
                    rem_d   = '0;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    dvd_d   = (sgn && a[XLEN-1]) ? -a : a;
                    dvs_d   = (sgn && b[XLEN-1]) ? -b : b;
                    rp_d    = '0;
                    cnt_d   = CW'(N);
                    negq_d  = sgn & (a[XLEN-1] ^ b[XLEN-1]);
                    negr_d  = sgn & a[XLEN-1];
                    state_d = CALC;
                end
            end
            CALC: begin
                dvd_d = dvd_next;
                rp_d  = r_chain[RADIX_BITS];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = negq_q ? -dvd_next : dvd_next;
                    rem_d   = negr_q ? -rem_next : rem_next;
                    state_d = DONE;
                end
            end
            DONE: if (ack_rdy) begin
                dz_d    = 1'b0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rp_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rp_q    <= rp_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rdy = (state_q == IDLE);
    assign ack = (state_q == DONE);
    assign quo = quo_q;
    assign rem = rem_q;
    assign dz  = dz_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_divseq.sv
// tb_divseq: directed and random checks of divseq against an arithmetic reference.
module tb_divseq;

    logic        clk = 1'b0;
    logic        rst, vld, sgn, ack_rdy;
    logic [31:0] a, b;
    logic        rdy, ack, dz, ovf;
    logic [31:0] quo, rem;
    int          vectors = 0;
    int          errs = 0;

    divseq #(.XLEN(32), .RADIX_BITS(2)) dut (
        .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .a(a), .b(b), .sgn(sgn),
        .ack(ack), .ack_rdy(ack_rdy), .quo(quo), .rem(rem), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ia, ib, input logic is,
                                  output logic [31:0] q, r, output logic edz, eov,
                                  output int lat);
        int sa, sb;
        sa = ia; sb = ib;
        edz = 1'b0; eov = 1'b0; lat = 16;
        if (ib == 0) begin
            q = 32'hFFFF_FFFF; r = ia; edz = 1'b1; lat = 1;
        end else if (is && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
            q = ia; r = 0; eov = 1'b1; lat = 1;
        end else if (is) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = ia / ib; r = ia % ib;
        end
    endfunction

    task automatic run(input logic [31:0] ia, ib, input logic is);
        logic [31:0] eq, er;
        logic        edz, eov;
        int          elat, lat;
        model(ia, ib, is, eq, er, edz, eov, elat);
        @(negedge clk);
        a = ia; b = ib; sgn = is; vld = 1'b1;
        check("rdy_idle", {31'b0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        vld = 1'b0; a = $urandom; b = $urandom; sgn = ~is;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack === 1'b1) break;
        end
        check("latency", 32'(lat), 32'(elat));
        check("quo", quo, eq);
        check("rem", rem, er);
        check("dz", {31'b0, dz}, {31'b0, edz});
        check("ovf", {31'b0, ovf}, {31'b0, eov});
    endtask

    task automatic release_ack();
        @(negedge clk);
        ack_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("rel_rdy", {31'b0, rdy}, 32'd1);
        check("rel_ack", {31'b0, ack}, 32'd0);
        check("rel_dz", {31'b0, dz}, 32'd0);
        check("rel_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        ack_rdy = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; vld = 1'b0; sgn = 1'b0; ack_rdy = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", {31'b0, rdy}, 32'd1);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_quo", quo, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_dz", {31'b0, dz}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ack_rdy", {31'b0, rdy}, 32'd1);
        ack_rdy = 1'b0;

        run(32'd100, 32'd7, 1'b0);                    release_ack();
        run(32'hFFFF_FFF9, 32'd2, 1'b1);              release_ack();
        run(32'd7, 32'hFFFF_FFFE, 1'b1);              release_ack();
        run(32'h1234, 32'd0, 1'b1);                   release_ack();
        run(32'h1234, 32'd0, 1'b0);                   release_ack();
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);      release_ack();
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);      release_ack();

        run(32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vld = 1'b1; a = $urandom; b = $urandom; sgn = $urandom;
            @(posedge clk);
            #1;
            check("bp_quo", quo, 32'd333);
            check("bp_rem", rem, 32'd1);
            check("bp_ack", {31'b0, ack}, 32'd1);
            check("bp_rdy", {31'b0, rdy}, 32'd0);
        end
        @(negedge clk);
        vld = 1'b0;
        release_ack();
        check("bp_quo_after", quo, 32'd333);

        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'd5; sgn = 1'b0; vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ack", {31'b0, ack}, 32'd0);
        check("abort_rdy", {31'b0, rdy}, 32'd1);
        check("abort_quo", quo, 32'd0);
        check("abort_rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_ack", {31'b0, ack}, 32'd0);
        run(32'hFFFF_FFFF, 32'h10, 1'b0);             release_ack();

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                3: rb = -$urandom_range(1, 20);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run(ra, rb, 1'($urandom));
            release_ack();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
